// File: rtl/conv_op_pkg.sv
// rtl/conv_op_pkg.sv - shared types and helpers for the gather convolution operator
package conv_op_pkg;

    localparam int ACC_W_DEF = 40;

    typedef enum logic [1:0] {LOAD, COMPUTE, EMIT} state_t;

    typedef logic signed [15:0]          elem_t;
    typedef logic signed [ACC_W_DEF-1:0] acc_t;

    function automatic int conv_out_dim(input int i, input int k, input int s, input int p);
        return (i + 2 * p - k) / s + 1;
    endfunction

    // Counter width that stays at least one bit for degenerate dimensions of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] sat32(input logic signed [63:0] a);
        if (a > 64'sd2147483647)
            return 32'h7fff_ffff;
        else if (a < -64'sd2147483648)
            return 32'h8000_0000;
        else
            return a[31:0];
    endfunction

endpackage

// File: rtl/conv_mac_sat.sv
// rtl/conv_mac_sat.sv - signed 16x16 MAC with gated accumulate and saturating readout
module conv_mac_sat
    import conv_op_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clear,
    input  logic        gate,
    input  elem_t       a,
    input  elem_t       b,
    output logic [31:0] sat_next
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [31:0]      prod;

    // sat_next reflects the sum including the current tap so the last tap's
    // result can be registered as the output in the same cycle.
    always_comb begin
        prod     = 32'(a) * 32'(b);
        acc_next = (clear ? '0 : acc) + (gate ? ACC_W'(prod) : '0);
        sat_next = sat32(64'(acc_next));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (en)
            acc <= acc_next;
    end

endmodule

// File: rtl/blk_671d42.sv
// rtl/blk_671d42.sv - strided zero-padded gather 2D convolution, one MAC per clock
module blk_671d42
    import conv_op_pkg::*;
#(
    parameter int IH    = 4,
    parameter int IW    = 6,
    parameter int KH    = 3,
    parameter int KW    = 2,
    parameter int SH    = 1,
    parameter int SW    = 2,
    parameter int PH    = 1,
    parameter int PW    = 0,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [31:0] input_data,
    input  logic [31:0] weight_data,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [31:0] output_data
);

    localparam int OH   = conv_out_dim(IH, KH, SH, PH);
    localparam int OW   = conv_out_dim(IW, KW, SW, PW);
    localparam int NPIX = IH * IW;
    localparam int NTAP = KH * KW;
    localparam int LW   = cnt_w(NPIX);
    localparam int TW   = cnt_w(NTAP);
    localparam int KHW  = cnt_w(KH);
    localparam int KWW  = cnt_w(KW);
    localparam int OHW  = cnt_w(OH);
    localparam int OWW  = cnt_w(OW);

    localparam logic [LW-1:0]  LOAD_LAST = LW'(NPIX - 1);
    localparam logic [KHW-1:0] KH_LAST   = KHW'(KH - 1);
    localparam logic [KWW-1:0] KW_LAST   = KWW'(KW - 1);
    localparam logic [OHW-1:0] OH_LAST   = OHW'(OH - 1);
    localparam logic [OWW-1:0] OW_LAST   = OWW'(OW - 1);

    state_t         state;
    logic [LW-1:0]  load_cnt;
    logic [KHW-1:0] kh_q;
    logic [KWW-1:0] kw_q;
    logic [OHW-1:0] oh_q;
    logic [OWW-1:0] ow_q;

    elem_t ifmap [NPIX];
    elem_t wbuf  [NTAP];

    int            ih_i;
    int            iw_i;
    logic          tap_ok;
    logic          first_tap;
    logic [LW-1:0] pix_addr;
    logic [TW-1:0] tap_addr;
    logic [31:0]   sat_next;

    logic unused_hi;
    assign unused_hi = ^{input_data[31:16], weight_data[31:16]};

    // Buffers are deliberately left out of reset; a frame always reloads them.
    always_ff @(posedge clk) begin
        if (state == LOAD && valid_in) begin
            ifmap[load_cnt] <= elem_t'(input_data[15:0]);
            if (int'(load_cnt) < NTAP)
                wbuf[TW'(load_cnt)] <= elem_t'(weight_data[15:0]);
        end
    end

    always_comb begin
        ih_i      = int'(oh_q) * SH - PH + int'(kh_q);
        iw_i      = int'(ow_q) * SW - PW + int'(kw_q);
        tap_ok    = (ih_i >= 0) && (ih_i < IH) && (iw_i >= 0) && (iw_i < IW);
        pix_addr  = tap_ok ? LW'(ih_i * IW + iw_i) : '0;
        tap_addr  = TW'(int'(kh_q) * KW + int'(kw_q));
        first_tap = (kh_q == '0) && (kw_q == '0);
    end

    conv_mac_sat #(.ACC_W(ACC_W)) u_mac (
        .clk      (clk),
        .rst      (rst),
        .en       (state == COMPUTE),
        .clear    (first_tap),
        .gate     (tap_ok),
        .a        (ifmap[pix_addr]),
        .b        (wbuf[tap_addr]),
        .sat_next (sat_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            ready_in    <= 1'b1;
            valid_out   <= 1'b0;
            output_data <= '0;
            load_cnt    <= '0;
            kh_q        <= '0;
            kw_q        <= '0;
            oh_q        <= '0;
            ow_q        <= '0;
        end else begin
            case (state)
                LOAD: if (valid_in) begin
                    if (load_cnt == LOAD_LAST) begin
                        load_cnt <= '0;
                        ready_in <= 1'b0;
                        state    <= COMPUTE;
                    end else begin
                        load_cnt <= load_cnt + LW'(1);
                    end
                end
                COMPUTE: begin
                    if (kw_q == KW_LAST) begin
                        kw_q <= '0;
                        if (kh_q == KH_LAST) begin
                            kh_q        <= '0;
                            output_data <= sat_next;
                            valid_out   <= 1'b1;
                            state       <= EMIT;
                        end else begin
                            kh_q <= kh_q + KHW'(1);
                        end
                    end else begin
                        kw_q <= kw_q + KWW'(1);
                    end
                end
                EMIT: if (ready_out) begin
                    valid_out <= 1'b0;
                    state     <= COMPUTE;
                    if (ow_q == OW_LAST) begin
                        ow_q <= '0;
                        if (oh_q == OH_LAST) begin
                            oh_q     <= '0;
                            state    <= LOAD;
                            ready_in <= 1'b1;
                        end else begin
                            oh_q <= oh_q + OHW'(1);
                        end
                    end else begin
                        ow_q <= ow_q + OWW'(1);
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
